// File: rtl/isa_decode_stage.sv
// ---------------------------------------------------------------------------
// isa_decode_stage
//
// Registered instruction-decode stage sitting between fetch and execute.
// Each accepted instruction word is split into its fields, classified as
// R / I / J1 / J2 (or flagged illegal), given a sign-extended immediate, and
// queued with its PC in a DEPTH-entry FIFO. Both sides use valid/ready.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   flush               synchronous; drops buffered entries and this cycle's input
//   in_valid/in_ready   fetch-side handshake
//   in_instr, in_pc     instruction word and its PC
//   out_valid/out_ready execute-side handshake
//   out_pc .. out_illegal  decoded head entry (registered)
//   count               FIFO occupancy
// ---------------------------------------------------------------------------
module isa_decode_stage #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [4:0]               out_op,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [4:0]               out_shamt,
    output logic [4:0]               out_alu_op,
    output logic [DATA_W-1:0]        out_imm,
    output logic [26:0]              out_target,
    output logic [1:0]               out_type,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IMM_W = 17;

    localparam logic [1:0] TYPE_R  = 2'b00;
    localparam logic [1:0] TYPE_I  = 2'b01;
    localparam logic [1:0] TYPE_J1 = 2'b10;
    localparam logic [1:0] TYPE_J2 = 2'b11;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [4:0]        op;
        logic [4:0]        rd;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        shamt;
        logic [4:0]        alu_op;
        logic [DATA_W-1:0] imm;
        logic [26:0]       target;
        logic [1:0]        itype;
        logic              illegal;
    } entry_t;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] raw);
        return DATA_W'(raw);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---- stage p0: combinational decode of the offered word ----
    entry_t dec_p0;

    always_comb begin
        dec_p0         = '0;
        dec_p0.pc      = in_pc;
        dec_p0.op      = in_instr[INSTR_W-1  -: 5];
        dec_p0.rd      = in_instr[INSTR_W-6  -: 5];
        dec_p0.rs      = in_instr[INSTR_W-11 -: 5];
        dec_p0.rt      = in_instr[INSTR_W-16 -: 5];
        dec_p0.shamt   = in_instr[INSTR_W-21 -: 5];
        dec_p0.alu_op  = in_instr[INSTR_W-26 -: 5];
        dec_p0.imm     = sext_imm(in_instr[INSTR_W-16 -: IMM_W]);
        dec_p0.target  = in_instr[INSTR_W-6 -: 27];
        dec_p0.itype   = TYPE_R;
        dec_p0.illegal = 1'b0;
        unique case (dec_p0.op)
            5'b00000:                                   dec_p0.itype = TYPE_R;
            5'b00010, 5'b00101, 5'b00110,
            5'b00111, 5'b01000:                         dec_p0.itype = TYPE_I;
            5'b00001, 5'b00011, 5'b10101, 5'b10110:     dec_p0.itype = TYPE_J1;
            5'b00100:                                   dec_p0.itype = TYPE_J2;
            default:                                    dec_p0.illegal = 1'b1;
        endcase
    end

    // ---- stage p1: FIFO storage and registered head entry ----
    entry_t             mem [DEPTH];
    entry_t             head_p1;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               vld_p1;

    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   rd_ptr_nx;
    logic [CNT_W-1:0]   count_nx;
    entry_t             head_nx;

    assign vld_p1   = (count_q != '0);
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = vld_p1 & out_ready & ~flush;

    always_comb begin
        rd_ptr_nx = pop ? next_ptr(rd_ptr) : rd_ptr;
        count_nx  = count_q;
        unique case ({push, pop})
            2'b10:   count_nx = count_q + CNT_W'(1);
            2'b01:   count_nx = count_q - CNT_W'(1);
            default: count_nx = count_q;
        endcase
        // The new head is the word being written this cycle when the read
        // pointer lands on the write slot (FIFO empty, or emptying to one).
        head_nx = (push && (rd_ptr_nx == wr_ptr)) ? dec_p0 : mem[rd_ptr_nx];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= dec_p0;
        end
    end

    // Head register is cleared on reset/flush so payload outputs read zero;
    // when the FIFO drains it simply holds the last entry.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_p1 <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            rd_ptr  <= rd_ptr_nx;
            count_q <= count_nx;
            if (count_nx != '0) begin
                head_p1 <= head_nx;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign count       = count_q;
    assign out_pc      = head_p1.pc;
    assign out_op      = head_p1.op;
    assign out_rd      = head_p1.rd;
    assign out_rs      = head_p1.rs;
    assign out_rt      = head_p1.rt;
    assign out_shamt   = head_p1.shamt;
    assign out_alu_op  = head_p1.alu_op;
    assign out_imm     = head_p1.imm;
    assign out_target  = head_p1.target;
    assign out_type    = head_p1.itype;
    assign out_illegal = head_p1.illegal;

endmodule
